// File: rtl/nibble_input_stage_if.sv
// Pin-side bundle of the nibble input stage: raw pins in, conditioned byte/toggle outputs.
interface nibble_input_stage_if;
   logic [3:0] din_raw;
   logic       valid_raw;
   logic       toggle_raw;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       nibble_pending;
   logic       drop;
   logic       toggle_state;
   logic       toggle_pulse;

   modport slave (
      input  din_raw, valid_raw, toggle_raw,
      output byte_out, byte_valid, nibble_pending, drop, toggle_state, toggle_pulse
   );

   modport master (
      output din_raw, valid_raw, toggle_raw,
      input  byte_out, byte_valid, nibble_pending, drop, toggle_state, toggle_pulse
   );
endinterface

// File: rtl/nibble_input_stage.sv
// Input front-end: synchronises raw pins, packs nibble pairs into bytes with a
// timeout on the half byte, and debounces the toggle pin into a level and a rise pulse.
module nibble_input_stage #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TIMEOUT         = 255
) (
   input logic             clk,
   input logic             reset,
   nibble_input_stage_if.slave bus
);

   localparam int unsigned NIB_W  = 4;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DEB_W  = 4;

   localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
   localparam logic [DEB_W-1:0] DEBOUNCE_C = DEB_W'(DEBOUNCE_CYCLES);

   typedef enum logic {
      EMPTY = 1'b0,
      HALF  = 1'b1
   } state_t;

   // synchroniser chains; din shares the valid depth so data lines up with its strobe
   logic [SYNC_STAGES-1:0]            valid_sync;
   logic [SYNC_STAGES-1:0]            toggle_sync;
   logic [SYNC_STAGES-1:0][NIB_W-1:0] din_sync;
   logic                              valid_prev;

   logic             strobe_c;
   logic [NIB_W-1:0] nibble_c;
   logic             toggle_c;

   // assembler state
   state_t            state_q, state_d;
   logic [NIB_W-1:0]  hi_q, hi_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BYTE_W-1:0] byte_q, byte_d;
   logic              byte_valid_q, byte_valid_d;
   logic              drop_q, drop_d;
   logic              pending_q, pending_d;

   // debouncer state
   logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             tstate_q, tstate_d;
   logic             tpulse_q, tpulse_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_sync  <= '0;
         toggle_sync <= '0;
         din_sync    <= '0;
         valid_prev  <= 1'b0;
      end else begin
         valid_sync  <= {valid_sync[SYNC_STAGES-2:0], bus.valid_raw};
         toggle_sync <= {toggle_sync[SYNC_STAGES-2:0], bus.toggle_raw};
         din_sync    <= {din_sync[SYNC_STAGES-2:0], bus.din_raw};
         valid_prev  <= valid_sync[SYNC_STAGES-1];
      end
   end

   assign strobe_c = valid_sync[SYNC_STAGES-1] & ~valid_prev;
   assign nibble_c = din_sync[SYNC_STAGES-1];
   assign toggle_c = toggle_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= EMPTY;
         hi_q         <= '0;
         cnt_q        <= '0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
         drop_q       <= 1'b0;
         pending_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         cnt_q        <= cnt_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         drop_q       <= drop_d;
         pending_q    <= pending_d;
      end
   end

   // a strobe in the timeout cycle completes the byte instead of dropping it
   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      cnt_d        = cnt_q;
      byte_d       = byte_q;
      byte_valid_d = 1'b0;
      drop_d       = 1'b0;
      case (state_q)
         EMPTY: begin
            if (strobe_c) begin
               hi_d    = nibble_c;
               cnt_d   = '0;
               state_d = HALF;
            end
         end
         HALF: begin
            if (strobe_c) begin
               byte_d       = {hi_q, nibble_c};
               byte_valid_d = 1'b1;
               state_d      = EMPTY;
            end else if (cnt_q == TIMEOUT_C) begin
               hi_d    = '0;
               drop_d  = 1'b1;
               state_d = EMPTY;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = EMPTY;
      endcase
      pending_d = (state_d == HALF);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb_cnt_q <= '0;
         tstate_q  <= 1'b0;
         tpulse_q  <= 1'b0;
      end else begin
         deb_cnt_q <= deb_cnt_d;
         tstate_q  <= tstate_d;
         tpulse_q  <= tpulse_d;
      end
   end

   // count consecutive disagreeing cycles; flip once the run reaches the threshold
   always_comb begin
      deb_cnt_d = '0;
      tstate_d  = tstate_q;
      tpulse_d  = 1'b0;
      if (toggle_c != tstate_q) begin
         if ((deb_cnt_q + 4'd1) == DEBOUNCE_C) begin
            tstate_d = ~tstate_q;
            tpulse_d = ~tstate_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 4'd1;
         end
      end
   end

   assign bus.byte_out       = byte_q;
   assign bus.byte_valid     = byte_valid_q;
   assign bus.nibble_pending = pending_q;
   assign bus.drop           = drop_q;
   assign bus.toggle_state   = tstate_q;
   assign bus.toggle_pulse   = tpulse_q;

endmodule

// File: tb/tb_nibble_input_stage.sv
// Scoreboard bench for nibble_input_stage: stimulus pushes timed expected events,
// a negedge monitor pops and compares every output event it observes.
module tb_nibble_input_stage;

   localparam int unsigned EV_BYTE   = 0;
   localparam int unsigned EV_DROP   = 1;
   localparam int unsigned EV_TSTATE = 2;
   localparam int unsigned EV_TPULSE = 3;

   typedef struct {
      int unsigned kind;
      logic [7:0]  data;
      int          cyc;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic ts_prev = 1'b0;
   ev_t  exp_q[$];

   nibble_input_stage_if bus ();

   nibble_input_stage #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .TIMEOUT        (8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input int unsigned kind, input logic [7:0] data, input int offset);
      ev_t e;
      e.kind = kind;
      e.data = data;
      e.cyc  = cyc + offset;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic got(input int unsigned kind, input logic [7:0] data);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d data=%h at cycle %0d, want none", kind, data, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.data !== data || e.cyc != cyc) begin
            errors++;
            $display("FAIL event: got kind=%0d data=%h cycle=%0d, want kind=%0d data=%h cycle=%0d",
                     kind, data, cyc, e.kind, e.data, e.cyc);
         end
      end
   endtask

   // monitor: fixed order within a cycle matches the order events are pushed
   always @(negedge clk) begin
      if (bus.byte_valid) got(EV_BYTE, bus.byte_out);
      if (bus.drop) got(EV_DROP, bus.byte_out);
      if (bus.toggle_state !== ts_prev) got(EV_TSTATE, {7'b0, bus.toggle_state});
      if (bus.toggle_pulse) got(EV_TPULSE, 8'h01);
      ts_prev = bus.toggle_state;
   end

   task automatic nib(input logic [3:0] d, input int hi, input int lo);
      bus.din_raw   = d;
      bus.valid_raw = 1'b1;
      step(hi);
      bus.valid_raw = 1'b0;
      step(lo);
   endtask

   function automatic logic [15:0] all_outs();
      return {bus.byte_out, bus.byte_valid, bus.nibble_pending, bus.drop,
              bus.toggle_state, bus.toggle_pulse, 3'b000};
   endfunction

   initial begin
      reset          = 1'b0;
      bus.din_raw    = 4'h0;
      bus.valid_raw  = 1'b0;
      bus.toggle_raw = 1'b0;
      step(1);

      // reset holds everything at zero despite random pin activity
      for (int i = 0; i < 5; i++) begin
         bus.din_raw    = 4'($urandom_range(0, 15));
         bus.valid_raw  = 1'($urandom_range(0, 1));
         bus.toggle_raw = 1'($urandom_range(0, 1));
         step(1);
         chk("reset_outputs", all_outs(), 16'h0000);
      end
      bus.valid_raw  = 1'b0;
      bus.toggle_raw = 1'b0;
      step(2);
      reset = 1'b1;
      step(10);
      chk("post_reset_idle", all_outs(), 16'h0000);

      // 0xA then 0x5 -> 0xA5, byte_valid three edges after the second rise
      nib(4'hA, 3, 3);
      chk("pending_between", 16'(bus.nibble_pending), 16'h0001);
      expect_ev(EV_BYTE, 8'hA5, 3);
      nib(4'h5, 3, 3);
      chk("pending_after_byte", 16'(bus.nibble_pending), 16'h0000);
      chk("byte_hold", 16'(bus.byte_out), 16'h00A5);

      // held valid: one strobe only, then the half byte times out (TIMEOUT=8)
      expect_ev(EV_DROP, 8'hA5, 12);
      bus.din_raw   = 4'h3;
      bus.valid_raw = 1'b1;
      step(5);
      chk("held_pending", 16'(bus.nibble_pending), 16'h0001);
      step(45);
      chk("held_dropped", 16'(bus.nibble_pending), 16'h0000);
      bus.valid_raw = 1'b0;
      step(4);

      // lone 0xC: drop nine cycles after pending rises, byte_out untouched
      expect_ev(EV_DROP, 8'hA5, 12);
      nib(4'hC, 3, 3);
      step(10);
      chk("drop_keeps_byte", 16'(bus.byte_out), 16'h00A5);

      // second strobe lands in the timeout cycle: byte wins, no drop
      expect_ev(EV_BYTE, 8'h69, 12);
      nib(4'h6, 3, 6);
      nib(4'h9, 3, 3);
      step(4);
      chk("race_pending", 16'(bus.nibble_pending), 16'h0000);

      // back-to-back valid edges every two cycles
      expect_ev(EV_BYTE, 8'hBE, 5);
      nib(4'hB, 1, 1);
      nib(4'hE, 1, 1);
      step(6);
      chk("b2b_byte", 16'(bus.byte_out), 16'h00BE);

      // toggle glitch of three cycles is ignored
      bus.toggle_raw = 1'b1;
      step(3);
      bus.toggle_raw = 1'b0;
      step(10);
      chk("glitch_ignored", 16'(bus.toggle_state), 16'h0000);

      // held toggle: rise at edge 6 with a pulse, fall with no pulse
      expect_ev(EV_TSTATE, 8'h01, 6);
      expect_ev(EV_TPULSE, 8'h01, 6);
      bus.toggle_raw = 1'b1;
      step(10);
      chk("toggle_high", 16'(bus.toggle_state), 16'h0001);
      expect_ev(EV_TSTATE, 8'h00, 6);
      bus.toggle_raw = 1'b0;
      step(10);

      // reset in HALF with a partly counted toggle returns to reset values
      nib(4'h7, 3, 3);
      chk("mid_pending", 16'(bus.nibble_pending), 16'h0001);
      bus.toggle_raw = 1'b1;
      step(3);
      reset          = 1'b0;
      bus.toggle_raw = 1'b0;
      step(1);
      chk("mid_reset_outputs", all_outs(), 16'h0000);
      reset = 1'b1;
      step(3);
      expect_ev(EV_BYTE, 8'h12, 9);
      nib(4'h1, 3, 3);
      nib(4'h2, 3, 3);
      step(4);
      chk("after_reset_byte", 16'(bus.byte_out), 16'h0012);

      // every expected event must have been observed within its window
      step(20);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events: got %0d outstanding, want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
